// File: rtl/branch_predictor_2bit_pkg.sv
// Shared types for the fetch-stage branch predictor: counter encoding, BTB entry
// layout and the saturating counter step.
package bp_pkg;

    // Widest tag any legal ENTRIES (>= 4) can need; narrower tags are zero-extended.
    localparam int BP_TAG_MAX_W = 28;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_ctr_e;

    localparam bp_ctr_e BP_CTR_RST = WNT;

    typedef struct packed {
        logic                    valid;
        logic [BP_TAG_MAX_W-1:0] tag;
        logic [31:0]             target;
        bp_ctr_e                 ctr;
    } bp_entry_t;

    function automatic bp_ctr_e sat_next(input bp_ctr_e ctr, input logic taken);
        bp_ctr_e nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != ST) nxt = bp_ctr_e'(ctr + 2'd1);
        end else begin
            if (ctr != SNT) nxt = bp_ctr_e'(ctr - 2'd1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predictor_2bit_perf_counter.sv
// Free-running 32-bit event counter that wraps to zero; used for predictor statistics.
module bp_perf_counter (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    output logic [31:0] cnt_o
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_predictor_2bit.sv
// Direct-mapped BTB with 2-bit saturating counters: combinational next-PC prediction
// for IF, trained one cycle later by control-flow instructions resolved in EX.
module branch_predictor_2bit
    import bp_pkg::*;
#(
    parameter int ENTRIES = 32,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = 30 - IDX_W
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] pc_if_i,
    output logic        pred_hit_o,
    output logic        pred_taken_o,
    output logic [31:0] pred_pc_o,
    input  logic        update_en_i,
    input  logic [31:0] pc_ex_i,
    input  logic        taken_ex_i,
    input  logic [31:0] target_ex_i,
    input  logic        is_jump_i,
    input  logic        mispredict_i,
    input  logic        clear_i,
    output logic [31:0] branch_cnt_o,
    output logic [31:0] mispred_cnt_o
);

    bp_entry_t table_q [ENTRIES];
    bp_entry_t table_d [ENTRIES];

    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] if_tag;
    logic [TAG_W-1:0] ex_tag;
    bp_entry_t        if_ent;
    bp_entry_t        ex_ent;
    logic             ex_hit;
    logic             unused_pc_bits;

    assign if_idx = pc_if_i[IDX_W+1:2];
    assign if_tag = pc_if_i[31:IDX_W+2];
    assign ex_idx = pc_ex_i[IDX_W+1:2];
    assign ex_tag = pc_ex_i[31:IDX_W+2];
    assign unused_pc_bits = ^{pc_if_i[1:0], pc_ex_i[1:0]};

    // Lookup reads registered state only, so a same-cycle update is not visible yet.
    assign if_ent       = table_q[if_idx];
    assign pred_hit_o   = if_ent.valid && (if_ent.tag == BP_TAG_MAX_W'(if_tag));
    assign pred_taken_o = pred_hit_o && if_ent.ctr[1];
    assign pred_pc_o    = pred_taken_o ? if_ent.target : (pc_if_i + 32'd4);

    assign ex_ent = table_q[ex_idx];
    assign ex_hit = ex_ent.valid && (ex_ent.tag == BP_TAG_MAX_W'(ex_tag));

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) table_d[i] = table_q[i];
        if (clear_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_d[i].valid = 1'b0;
                table_d[i].ctr   = BP_CTR_RST;
            end
        end else if (update_en_i) begin
            if (ex_hit) begin
                if (is_jump_i) begin
                    table_d[ex_idx].ctr    = ST;
                    table_d[ex_idx].target = target_ex_i;
                end else begin
                    table_d[ex_idx].ctr = sat_next(ex_ent.ctr, taken_ex_i);
                    if (taken_ex_i) table_d[ex_idx].target = target_ex_i;
                end
            end else if (taken_ex_i) begin
                // Miss on a taken transfer evicts whatever alias occupied the slot.
                table_d[ex_idx].valid  = 1'b1;
                table_d[ex_idx].tag    = BP_TAG_MAX_W'(ex_tag);
                table_d[ex_idx].target = target_ex_i;
                table_d[ex_idx].ctr    = is_jump_i ? ST : WT;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: BP_CTR_RST};
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) table_q[i] <= table_d[i];
        end
    end

    // Statistics keep counting even when clear_i drops the table update.
    bp_perf_counter u_branch_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (update_en_i),
        .cnt_o  (branch_cnt_o)
    );

    bp_perf_counter u_mispred_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (update_en_i & mispredict_i),
        .cnt_o  (mispred_cnt_o)
    );

endmodule

// File: tb/tb_branch_predictor_2bit.sv
// Scoreboard bench for branch_predictor_2bit: directed scenarios plus random traffic
// checked against a behavioural BTB model.
module tb_branch_predictor_2bit;

    localparam int ENTRIES = 32;
    localparam int IDX_SH  = 2;
    localparam int TAG_SH  = 7;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] pc_if_i = '0;
    logic        pred_hit_o;
    logic        pred_taken_o;
    logic [31:0] pred_pc_o;
    logic        update_en_i = 1'b0;
    logic [31:0] pc_ex_i = '0;
    logic        taken_ex_i = 1'b0;
    logic [31:0] target_ex_i = '0;
    logic        is_jump_i = 1'b0;
    logic        mispredict_i = 1'b0;
    logic        clear_i = 1'b0;
    logic [31:0] branch_cnt_o;
    logic [31:0] mispred_cnt_o;

    always #5 clk = ~clk;

    branch_predictor_2bit #(.ENTRIES(ENTRIES)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .pc_if_i       (pc_if_i),
        .pred_hit_o    (pred_hit_o),
        .pred_taken_o  (pred_taken_o),
        .pred_pc_o     (pred_pc_o),
        .update_en_i   (update_en_i),
        .pc_ex_i       (pc_ex_i),
        .taken_ex_i    (taken_ex_i),
        .target_ex_i   (target_ex_i),
        .is_jump_i     (is_jump_i),
        .mispredict_i  (mispredict_i),
        .clear_i       (clear_i),
        .branch_cnt_o  (branch_cnt_o),
        .mispred_cnt_o (mispred_cnt_o)
    );

    typedef struct {
        logic        hit;
        logic        taken;
        logic [31:0] pc;
        logic [31:0] bcnt;
        logic [31:0] mcnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Behavioural model: per-slot valid/tag/target and an integer confidence 0..3.
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    logic [31:0] m_bcnt;
    logic [31:0] m_mcnt;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> IDX_SH) % ENTRIES);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return int'(pc >> TAG_SH);
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 1;
        end
        m_bcnt = '0;
        m_mcnt = '0;
    endfunction

    function automatic exp_t m_lookup(input logic [31:0] pc);
        exp_t e;
        int   i;
        i       = idx_of(pc);
        e.hit   = m_valid[i] && (m_tag[i] == tag_of(pc));
        e.taken = e.hit && (m_ctr[i] >= 2);
        e.pc    = e.taken ? m_tgt[i] : pc + 32'd4;
        e.bcnt  = m_bcnt;
        e.mcnt  = m_mcnt;
        return e;
    endfunction

    function automatic void m_update(input logic upd, input logic [31:0] pc, input logic tk,
                                     input logic [31:0] tgt, input logic jmp,
                                     input logic misp, input logic clr);
        int i;
        bit hit;
        if (upd) begin
            m_bcnt = m_bcnt + 32'd1;
            if (misp) m_mcnt = m_mcnt + 32'd1;
        end
        if (clr) begin
            for (int k = 0; k < ENTRIES; k++) begin
                m_valid[k] = 1'b0;
                m_ctr[k]   = 1;
            end
        end else if (upd) begin
            i   = idx_of(pc);
            hit = m_valid[i] && (m_tag[i] == tag_of(pc));
            if (hit) begin
                if (jmp) begin
                    m_ctr[i] = 3;
                    m_tgt[i] = tgt;
                end else if (tk) begin
                    m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    m_tgt[i] = tgt;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (tk) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = tag_of(pc);
                m_tgt[i]   = tgt;
                m_ctr[i]   = jmp ? 3 : 2;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs (already at the falling edge) and record the expectation.
    task automatic issue(input logic [31:0] pcif, input logic upd, input logic [31:0] pcex,
                         input logic tk, input logic [31:0] tgt, input logic jmp,
                         input logic misp, input logic clr);
        pc_if_i     = pcif;
        update_en_i = upd;
        clear_i     = clr;
        if (upd) begin
            pc_ex_i      = pcex;
            taken_ex_i   = tk;
            target_ex_i  = tgt;
            is_jump_i    = jmp;
            mispredict_i = misp;
        end else begin
            pc_ex_i      = 'x;
            taken_ex_i   = 'x;
            target_ex_i  = 'x;
            is_jump_i    = 'x;
            mispredict_i = 'x;
        end
        sb_q.push_back(m_lookup(pcif));
        m_update(upd, pcex, tk, tgt, jmp, misp, clr);
    endtask

    task automatic cycle(input logic [31:0] pcif, input logic upd, input logic [31:0] pcex,
                         input logic tk, input logic [31:0] tgt, input logic jmp,
                         input logic misp, input logic clr);
        @(negedge clk);
        issue(pcif, upd, pcex, tk, tgt, jmp, misp, clr);
    endtask

    task automatic look(input logic [31:0] pcif);
        cycle(pcif, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        update_en_i = 1'b0;
        clear_i     = 1'b0;
        #3 rst_ni = 1'b0;
        m_reset();
        @(negedge clk);
        #3 rst_ni = 1'b1;
    endtask

    // Monitor: the predictor presents a result every cycle; compare each queued one.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("pred_hit",    {31'b0, pred_hit_o},   {31'b0, e.hit});
                chk("pred_taken",  {31'b0, pred_taken_o}, {31'b0, e.taken});
                chk("pred_pc",     pred_pc_o,             e.pc);
                chk("branch_cnt",  branch_cnt_o,          e.bcnt);
                chk("mispred_cnt", mispred_cnt_o,         e.mcnt);
            end
        end
    end

    initial begin
        logic [31:0] rpc;
        logic [31:0] rtgt;
        logic        rjmp;
        m_reset();

        // Reset state visible while rst_ni is held low.
        look(32'h0000_0100);
        #3 rst_ni = 1'b1;
        look(32'h0000_0100);
        look(32'hFFFF_FFFC);

        // Allocation, then confidence decays with not-taken outcomes.
        cycle(32'h0000_0100, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0080, 1'b0, 1'b1, 1'b0);
        look(32'h0000_0100);
        for (int k = 0; k < 4; k++)
            cycle(32'h0000_0100, 1'b1, 32'h0000_0100, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
        look(32'h0000_0100);

        // Aliasing on the same index with a different tag.
        cycle(32'h0000_0100, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0080, 1'b0, 1'b0, 1'b0);
        cycle(32'h0000_0180, 1'b1, 32'h0000_0180, 1'b1, 32'h0000_0300, 1'b0, 1'b1, 1'b0);
        look(32'h0000_0100);
        look(32'h0000_0180);

        // Same-cycle lookup sees the old entry; then clear wins over an update.
        cycle(32'h0000_0200, 1'b1, 32'h0000_0200, 1'b1, 32'h0000_0040, 1'b1, 1'b0, 1'b0);
        look(32'h0000_0200);
        cycle(32'h0000_0200, 1'b1, 32'h0000_0300, 1'b1, 32'h0000_0500, 1'b0, 1'b1, 1'b1);
        look(32'h0000_0200);
        look(32'h0000_0180);
        look(32'h0000_0300);

        // Statistics from a clean reset: 10 updates, 3 flagged mispredicts.
        do_reset();
        for (int k = 0; k < 10; k++)
            cycle(32'h0000_0400, 1'b1, 32'h0000_0400 + 32'(k * 4), 1'b1, 32'h0000_1000,
                  1'b0, (k % 3 == 0 && k < 9) ? 1'b1 : 1'b0, 1'b0);
        @(negedge clk);
        #2;
        chk("branch_cnt_after_10", branch_cnt_o, 32'd10);
        chk("mispred_cnt_after_3", mispred_cnt_o, 32'd3);

        // Counter wrap from all-ones.
        @(negedge clk);
        force dut.u_branch_cnt.cnt_q = 32'hFFFF_FFFF;
        force dut.u_mispred_cnt.cnt_q = 32'hFFFF_FFFF;
        m_bcnt = 32'hFFFF_FFFF;
        m_mcnt = 32'hFFFF_FFFF;
        issue(32'h0000_0400, 1'b1, 32'h0000_0600, 1'b1, 32'h0000_2000, 1'b0, 1'b1, 1'b0);
        #4;
        release dut.u_branch_cnt.cnt_q;
        release dut.u_mispred_cnt.cnt_q;
        look(32'h0000_0600);
        @(negedge clk);
        #2;
        chk("branch_cnt_wrap", branch_cnt_o, 32'd0);

        // Reset arriving before an update's edge discards that update.
        cycle(32'h0000_0500, 1'b1, 32'h0000_0500, 1'b1, 32'h0000_0077, 1'b0, 1'b1, 1'b0);
        #3 rst_ni = 1'b0;
        m_reset();
        look(32'h0000_0500);
        #3 rst_ni = 1'b1;
        look(32'h0000_0500);

        // Random traffic over a small PC pool so hits, aliases and decay all occur.
        for (int n = 0; n < 600; n++) begin
            rpc  = ($urandom_range(0, 3) << TAG_SH) | ($urandom_range(0, ENTRIES - 1) << IDX_SH)
                   | 32'($urandom_range(0, 3));
            rtgt = $urandom;
            rjmp = ($urandom_range(0, 4) == 0);
            cycle(($urandom_range(0, 1) == 0) ? rpc
                      : (($urandom_range(0, 3) << TAG_SH) | ($urandom_range(0, ENTRIES - 1) << IDX_SH)),
                  ($urandom_range(0, 9) < 7), rpc,
                  rjmp ? 1'b1 : 1'($urandom_range(0, 1)), rtgt, rjmp,
                  1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));
        end

        begin
            int budget;
            budget = 20;
            while (sb_q.size() > 0 && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            @(negedge clk);
            #3;
            if (sb_q.size() > 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL drain: %0d results still pending, required 0", sb_q.size());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
